mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_unit_iter_datapath.sv | 84 ++++++++
 rtl/mul_div_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared operation and FSM state encodings for the multiply/divide unit.
package mul_div_unit_pkg;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_GTU  = 5'd5;
   localparam logic [4:0] OP_MUL  = 5'd6;
   localparam logic [4:0] OP_DIV  = 5'd7;
   localparam logic [4:0] OP_RDLO = 5'd8;
   localparam logic [4:0] OP_RDHI = 5'd9;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   function automatic logic is_iter_op(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_iter_datapath.sv
// Bit-serial shift-add multiplier / restoring divider on operand magnitudes,
// with sign restoration applied to the outputs.
module iter_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic             sgn_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rtry;
   logic [2*WIDTH-1:0] prod;

   // |MIN| is representable as an unsigned WIDTH-bit value, so no extra bit is needed.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   always_comb begin
      acc_d    = acc_q;
      sh_d     = sh_q;
      mb_d     = mb_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      sum      = acc_q + (sh_q[0] ? {1'b0, mb_q} : '0);
      rtry     = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
      if (load_i) begin
         acc_d    = '0;
         sh_d     = mag(a_i, sgn_i);
         mb_d     = mag(b_i, sgn_i);
         div_d    = div_i;
         neg_lo_d = sgn_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         neg_hi_d = div_i ? (sgn_i && a_i[WIDTH-1]) : (sgn_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]));
      end else if (step_i) begin
         if (div_q) begin
            if (rtry >= {1'b0, mb_q}) begin
               acc_d = rtry - {1'b0, mb_q};
               sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rtry;
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = {1'b0, sum[WIDTH:1]};
            sh_d  = {sum[0], sh_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      mb_q     <= mb_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
   end

   assign prod = {acc_q[WIDTH-1:0], sh_q};

   always_comb begin
      if (div_q) begin
         hi_o = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         lo_o = neg_lo_q ? -sh_q : sh_q;
      end else begin
         {hi_o, lo_o} = neg_lo_q ? -prod : prod;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// ALU with an iterative multiply/divide engine; FSM, hi/lo registers and
// the combinational result mux live here.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] a_q;
   logic             bz_q;
   logic             div_q;
   logic             accept;
   logic             step;
   logic [WIDTH-1:0] dp_hi;
   logic [WIDTH-1:0] dp_lo;

   assign accept = start && (state_q == ST_IDLE) && is_iter_op(op);

   iter_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .load_i (accept),
      .step_i (step),
      .div_i  (op == OP_DIV),
      .sgn_i  (sgn),
      .a_i    (a),
      .b_i    (b),
      .hi_o   (dp_hi),
      .lo_o   (dp_lo)
   );

   // RUN spends one extra cycle at cnt==WIDTH so done lands WIDTH+2 edges after start.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               state_d = ST_FINISH;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (div_q && bz_q) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = dp_hi;
               lo_d = dp_lo;
            end
            if (div_q) dz_d = bz_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= a;
         bz_q  <= (b == '0);
         div_q <= (op == OP_DIV);
      end
   end

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_GTU:  result = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_RDLO: result = lo_q;
         OP_RDHI: result = hi_q;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);
   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign dz   = dz_q;

endmodule
